// File: rtl/adc_scan_capture_pkg.sv
// Shared types, frame geometry and helpers for the ADC scan capture block.
package adc_scan_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP,
        UPDATE
    } state_t;

    // Frame geometry, SCLK periods numbered 1..FRAME_LEN
    localparam int unsigned FRAME_LEN  = 16;
    localparam int unsigned ADDR_FIRST = 3;
    localparam int unsigned ADDR_LAST  = 5;
    localparam int unsigned DATA_FIRST = 5;
    localparam int unsigned DATA_LAST  = 16;
    localparam int unsigned CODE_W     = DATA_LAST - DATA_FIRST + 1;
    localparam int unsigned MEAS_W     = 8;
    localparam int unsigned NUM_FRAMES = 5;

    // One 8-bit measurement per channel, captured per scan
    typedef struct packed {
        logic [MEAS_W-1:0] vin;
        logic [MEAS_W-1:0] vout;
        logic [MEAS_W-1:0] iout;
        logic [MEAS_W-1:0] temp;
    } meas_t;

    // DIN value for a given 1-based SCLK period: address MSB-first inside the address window
    function automatic logic addr_bit(input logic [2:0] addr, input logic [4:0] period);
        logic b;
        b = 1'b0;
        if (period >= 5'(ADDR_FIRST) && period <= 5'(ADDR_LAST))
            b = addr[2'(5'(ADDR_LAST) - period)];
        return b;
    endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One 16-period SCLK frame: drives DIN on falling edges, samples DOUT on rising edges.
module adc_spi_frame
    import adc_scan_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        addr,
    input  logic              dout,
    output logic              sclk,
    output logic              din,
    output logic [CODE_W-1:0] code,
    output logic              done_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_LEN);

    logic             active;
    logic [DIV_W-1:0] div;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       addr_q;
    logic             half_end;

    assign half_end = (div == DIV_W'(CLK_DIV - 1));

    // Frame completes at the end of the high half of the last period
    assign done_c = active && sclk && half_end && (bit_cnt == BIT_W'(FRAME_LEN - 1));

    // SCLK half-period sequencing, DIN launch and DOUT capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            sclk    <= 1'b1;
            din     <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
            code    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            din     <= addr_bit(addr, 5'd1);
            div     <= '0;
            bit_cnt <= '0;
            addr_q  <= addr;
        end else if (active) begin
            if (half_end) begin
                div <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                    if (bit_cnt >= BIT_W'(DATA_FIRST - 1))
                        code <= {code[CODE_W-2:0], dout};
                end else if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                    active <= 1'b0;
                end else begin
                    sclk    <= 1'b0;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    din     <= addr_bit(addr_q, 5'(bit_cnt) + 5'd2);
                end
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_scan_capture.sv
// Scans four ADC channels in a pipelined 5-frame sequence and publishes all results at once.
module adc_scan_capture
    import adc_scan_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned SCAN_GAP = 50000,
    parameter logic [2:0]  CH_VIN   = 3'd0,
    parameter logic [2:0]  CH_VOUT  = 3'd1,
    parameter logic [2:0]  CH_IOUT  = 3'd2,
    parameter logic [2:0]  CH_TEMP  = 3'd3
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       EN,
    output logic       ADC_CS_N,
    output logic       ADC_SCLK,
    output logic       ADC_DIN,
    input  logic       ADC_DOUT,
    output logic [3:0] VinH,
    output logic [3:0] VinL,
    output logic [3:0] VoutH,
    output logic [3:0] VoutL,
    output logic [3:0] IoutH,
    output logic [3:0] IoutL,
    output logic [3:0] TempH,
    output logic [3:0] TempL,
    output logic       SCAN_DONE,
    output logic       BUSY
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_LAST = (SCAN_GAP > 0) ? SCAN_GAP - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    state_t              state;
    logic [DIV_W-1:0]    div;
    logic [2:0]          frame;
    logic [GAP_W-1:0]    gap_cnt;
    meas_t               shadow;
    meas_t               shown;
    logic                frame_start_c;
    logic                frame_done_c;
    logic [2:0]          chan_addr_c;
    logic [CODE_W-1:0]   code;
    logic [3:0]          unused_code_lsbs;
    logic                div_end;

    assign div_end          = (div == DIV_W'(CLK_DIV - 1));
    assign frame_start_c    = (state == CS_SETUP) && div_end;
    assign unused_code_lsbs = code[3:0];

    // Address sent in each frame; the fifth frame re-addresses VIN to flush the pipeline
    always_comb begin
        chan_addr_c = CH_VIN;
        case (frame)
            3'd0:    chan_addr_c = CH_VIN;
            3'd1:    chan_addr_c = CH_VOUT;
            3'd2:    chan_addr_c = CH_IOUT;
            3'd3:    chan_addr_c = CH_TEMP;
            default: chan_addr_c = CH_VIN;
        endcase
    end

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk    (CLOCK_50),
        .rst    (RST),
        .start  (frame_start_c),
        .addr   (chan_addr_c),
        .dout   (ADC_DOUT),
        .sclk   (ADC_SCLK),
        .din    (ADC_DIN),
        .code   (code),
        .done_c (frame_done_c)
    );

    assign VinH  = shown.vin[7:4];
    assign VinL  = shown.vin[3:0];
    assign VoutH = shown.vout[7:4];
    assign VoutL = shown.vout[3:0];
    assign IoutH = shown.iout[7:4];
    assign IoutL = shown.iout[3:0];
    assign TempH = shown.temp[7:4];
    assign TempL = shown.temp[3:0];

    // Scan sequencer: chip select framing, result shadowing and atomic publish
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ADC_CS_N  <= 1'b1;
            div       <= '0;
            frame     <= '0;
            gap_cnt   <= '0;
            shadow    <= '0;
            shown     <= '0;
            SCAN_DONE <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            SCAN_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (EN) begin
                        state    <= CS_SETUP;
                        ADC_CS_N <= 1'b0;
                        BUSY     <= 1'b1;
                        div      <= '0;
                        frame    <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_end) begin
                        div   <= '0;
                        state <= SHIFT;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (frame_done_c) begin
                        state    <= CS_HOLD;
                        ADC_CS_N <= 1'b1;
                        // Code returned now belongs to the previous frame's address
                        case (frame)
                            3'd1:    shadow.vin  <= code[CODE_W-1:CODE_W-MEAS_W];
                            3'd2:    shadow.vout <= code[CODE_W-1:CODE_W-MEAS_W];
                            3'd3:    shadow.iout <= code[CODE_W-1:CODE_W-MEAS_W];
                            3'd4:    shadow.temp <= code[CODE_W-1:CODE_W-MEAS_W];
                            default: ;
                        endcase
                    end
                end
                CS_HOLD: begin
                    if (div_end) begin
                        div <= '0;
                        if (frame == 3'(NUM_FRAMES - 1)) begin
                            frame     <= '0;
                            state     <= UPDATE;
                            shown     <= shadow;
                            SCAN_DONE <= 1'b1;
                        end else begin
                            frame    <= frame + 3'd1;
                            state    <= CS_SETUP;
                            ADC_CS_N <= 1'b0;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                UPDATE: begin
                    state   <= GAP;
                    BUSY    <= 1'b0;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        if (EN) begin
                            state    <= CS_SETUP;
                            ADC_CS_N <= 1'b0;
                            BUSY     <= 1'b1;
                            div      <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_scan_capture.md
ADC_SCAN_CAPTURE -- requirements
Module: adc_scan_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25; CLOCK_50 cycles per SCLK half-period (1 MHz SCLK).
REQ-002 SHALL have parameter SCAN_GAP, default 50000; idle CLOCK_50 cycles between scans (1 ms).
REQ-003 SHALL have parameters CH_VIN, CH_VOUT, CH_IOUT, CH_TEMP, defaults 0, 1, 2, 3; 3-bit ADC channel addresses.
REQ-004 SHALL have port CLOCK_50, input, 1, sole clock, all logic on the rising edge.
REQ-005 SHALL have port RST, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port EN, input, 1, scanning enable.
REQ-007 SHALL have port ADC_CS_N, output, 1, ADC chip select (active-low).
REQ-008 SHALL have port ADC_SCLK, output, 1, ADC serial clock; idles high.
REQ-009 SHALL have port ADC_DIN, output, 1, serial address to the ADC.
REQ-010 SHALL have port ADC_DOUT, input, 1, serial data from the ADC.
REQ-011 SHALL have ports VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL, each output, 4, high/low hex nibble of the 8-bit measurement.
REQ-012 SHALL have port SCAN_DONE, output, 1, one-cycle pulse when the nibble outputs update.
REQ-013 SHALL have port BUSY, output, 1, high while a scan is in progress.

Function
REQ-014 Each frame SHALL be CS_N low, then 16 SCLK periods, then CS_N high; CS_N falls one half-period before the first SCLK falling edge and rises one half-period after the 16th rising edge.
REQ-015 ADC_DIN SHALL change only on SCLK falling edges; it carries the next channel address MSB-first during SCLK periods 3-5, otherwise 0.
REQ-016 ADC_DOUT SHALL be sampled in the CLOCK_50 cycle where SCLK goes low to high; bits from periods 5-16 form a 12-bit code, MSB first.
REQ-017 Conversion is pipelined: the code returned in frame n SHALL belong to the address sent in frame n-1.
REQ-018 A scan SHALL be 5 frames, addressing VIN, VOUT, IOUT, TEMP, then VIN again. The frame-1 result is discarded. Frames 2-5 return VIN, VOUT, IOUT, TEMP.
REQ-019 Each 8-bit measurement SHALL be code[11:4] (truncation, no rounding). The H nibble is [7:4] and the L nibble is [3:0].
REQ-020 Results SHALL be collected in shadow registers. All eight nibble outputs SHALL update together in the single cycle SCAN_DONE is high, so outputs never mix scans.
REQ-021 The FSM SHALL have the states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, UPDATE.
REQ-022 FSM transitions SHALL be:
- IDLE -> CS_SETUP when EN=1.
- CS_SETUP -> SHIFT after CLK_DIV cycles.
- SHIFT -> CS_HOLD after the 16th rising edge plus CLK_DIV cycles.
- CS_HOLD -> CS_SETUP (next frame) or -> UPDATE (after frame 5), after CLK_DIV cycles with CS_N high.
- UPDATE -> GAP (1 cycle).
- GAP -> CS_SETUP after SCAN_GAP cycles if EN=1, else -> IDLE.
REQ-023 EN falling mid-scan SHALL NOT abort the scan; the scan completes and updates the outputs, then the FSM enters IDLE.
REQ-024 BUSY SHALL be high in CS_SETUP, SHIFT, CS_HOLD, UPDATE; low in IDLE and GAP.
REQ-025 The divider SHALL count 0..CLK_DIV-1 and wrap. The bit counter SHALL count 0..15, and the frame counter 0..4.

Reset
REQ-026 RST high SHALL immediately force: state IDLE, ADC_CS_N=1, ADC_SCLK=1, ADC_DIN=0, all nibbles 0, shadows 0, SCAN_DONE=0, BUSY=0, all counters 0.
REQ-027 RST asserted mid-frame SHALL abandon the frame. No partial result reaches the outputs. The first scan after release starts again at frame 1.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the 16-bit frame length, the address bit positions (3-5) and the data bit window (5-16).
REQ-029 One sub-module, adc_spi_frame, SHALL perform a single 16-bit SCLK/DIN/DOUT frame with start/done handshake. The scan sequencing and shadowing stay in adc_scan_capture.

Verification
REQ-030 ADC model returns 0xABC, 0x123, 0xFF0, 0x7F4 for channels 0-3; EN=1 -> VinH/L=A/B, VoutH/L=1/2, IoutH/L=F/F, TempH/L=7/F, with one SCAN_DONE per scan.
REQ-031 Check SCLK timing: SCLK period 50 cycles; exactly 16 rising edges per CS_N low window; DIN at periods 3-5 matches the sequence 0,1,2,3,0.
REQ-032 Pipeline check: the model returns address-tagged codes (code = addr<<8) -> each output pair matches its own channel and never the previous address.
REQ-033 EN deasserted during frame 3 -> scan completes, SCAN_DONE pulses once, BUSY falls, CS_N stays high thereafter.
REQ-034 RST pulsed mid-SHIFT of frame 4 -> CS_N=1 and outputs 0 in the same cycle; after release, a full 5-frame scan runs before the first SCAN_DONE.
REQ-035 Model changes codes between scans -> outputs hold old values until the SCAN_DONE cycle, then all eight nibbles change in that same cycle.
